// File: rtl/booth_r4_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states,
// Booth digit encoding and the triple-to-digit decoder.
package booth_r4_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        BD_ZERO,
        BD_POS1,
        BD_POS2,
        BD_NEG1,
        BD_NEG2
    } booth_digit_t;

    // Triple is {b[i+1], b[i], b[i-1]} of the multiplier.
    function automatic booth_digit_t booth_decode(input logic [2:0] t);
        booth_digit_t d;
        case (t)
            3'b001, 3'b010: d = BD_POS1;
            3'b011:         d = BD_POS2;
            3'b100:         d = BD_NEG2;
            3'b101, 3'b110: d = BD_NEG1;
            default:        d = BD_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_addsub.sv
// N-bit ripple-carry adder/subtractor: result = reg1 + reg2 (op=0) or
// reg1 - reg2 (op=1, two's complement via inverted reg2 and carry-in).
module booth_r4_addsub #(
    parameter int N = 32
) (
    input  logic [N-1:0] reg1,
    input  logic [N-1:0] reg2,
    input  logic         op,
    output logic [N-1:0] result,
    output logic         cout
);

    logic [N-1:0] w_b;
    logic [N:0]   w_c;

    assign w_b    = reg2 ^ {N{op}};
    assign w_c[0] = op;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign result[i] = reg1[i] ^ w_b[i] ^ w_c[i];
        assign w_c[i+1]  = (reg1[i] & w_b[i]) | (reg1[i] & w_c[i]) | (w_b[i] & w_c[i]);
    end

    assign cout = w_c[N];

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier: one shared (N+2)-bit adder,
// two multiplier bits retired per cycle, valid/ready on both sides.
module booth_r4_seq_mult
    import booth_r4_pkg::*;
#(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product,
    output logic             busy
);

    localparam int CNT_W = (N / 2 > 1) ? $clog2(N / 2) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N / 2 - 1);

    state_t                 r_state;
    state_t                 w_state_next;

    logic signed [N+1:0]    r_acc;
    logic [N-1:0]           r_mq;
    logic                   r_qm1;
    logic signed [N+1:0]    r_mcand;
    logic [CNT_W-1:0]       r_count;
    logic [2*N-1:0]         r_product;

    booth_digit_t           w_digit;
    logic [N+1:0]           w_operand;
    logic                   w_op;
    logic [N+1:0]           w_sum;
    logic                   w_unused_cout;
    logic signed [2*N+2:0]  w_shift;
    logic [N+1:0]           w_acc_next;
    logic [N-1:0]           w_mq_next;
    logic                   w_qm1_next;
    logic                   w_accept;
    logic                   w_last;

    assign w_digit  = booth_decode({r_mq[1:0], r_qm1});
    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_count == LAST_CNT);

    // Zero digits still pass through the adder so every step has the same timing.
    always_comb begin
        w_operand = '0;
        w_op      = 1'b0;
        case (w_digit)
            BD_POS1: begin w_operand = r_mcand;      w_op = 1'b0; end
            BD_POS2: begin w_operand = r_mcand << 1; w_op = 1'b0; end
            BD_NEG1: begin w_operand = r_mcand;      w_op = 1'b1; end
            BD_NEG2: begin w_operand = r_mcand << 1; w_op = 1'b1; end
            default: begin w_operand = '0;           w_op = 1'b0; end
        endcase
    end

    booth_r4_addsub #(
        .N(N + 2)
    ) u_addsub (
        .reg1   (r_acc),
        .reg2   (w_operand),
        .op     (w_op),
        .result (w_sum),
        .cout   (w_unused_cout)
    );

    assign w_shift    = $signed({w_sum, r_mq, r_qm1}) >>> 2;
    assign w_acc_next = w_shift[2*N+2:N+1];
    assign w_mq_next  = w_shift[N:1];
    assign w_qm1_next = w_shift[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_accept) w_state_next = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_mq      <= '0;
            r_qm1     <= 1'b0;
            r_mcand   <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc   <= '0;
                        r_mq    <= multiplier;
                        r_qm1   <= 1'b0;
                        r_mcand <= {{2{multiplicand[N-1]}}, multiplicand};
                        r_count <= '0;
                    end
                end
                ITER: begin
                    r_acc   <= w_acc_next;
                    r_mq    <= w_mq_next;
                    r_qm1   <= w_qm1_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) r_product <= {w_acc_next[N-1:0], w_mq_next};
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed bench for booth_r4_seq_mult at N=8, plus a short seeded sweep
// against the bench's own signed-multiply reference.
module tb_booth_r4_seq_mult;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    booth_r4_seq_mult #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one pair, check latency and product, hold DONE for 'stall' cycles, then drain.
    task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] exp, input int stall);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        multiplicand = a;
        multiplier   = b;
        in_valid     = 1'b1;
        tick();
        in_valid     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, N / 2);
        chk({tag, "_product"}, product, exp);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_hold"}, {out_valid, product}, {1'b1, exp});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drain"}, {in_ready, out_valid, busy}, 3'b100);
    endtask

    initial begin
        logic [N-1:0]   ra;
        logic [N-1:0]   rb;
        logic [2*N-1:0] rexp;

        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_ctrl", {in_ready, out_valid, busy}, 3'b100);
        chk("reset_product", product, 16'h0000);

        // Idle without handshake: nothing starts
        tick();
        chk("idle_stays", {in_ready, busy}, 2'b10);

        do_op("t1_7x3", 8'd7, 8'd3, 16'h0015, 0);
        do_op("t2_m128xm128", 8'h80, 8'h80, 16'h4000, 0);
        do_op("t3_m5x6", 8'hFB, 8'd6, 16'hFFE2, 0);
        do_op("t3_127xm128", 8'd127, 8'h80, 16'hC080, 0);

        // Backpressure with in_valid pulses that must be ignored
        multiplicand = 8'd9;
        multiplier   = 8'd10;
        in_valid     = 1'b1;
        tick();
        in_valid     = 1'b0;
        chk("bp_busy_iter", {in_ready, busy}, 2'b01);
        repeat (N / 2) tick();
        chk("bp_done", {out_valid, product}, {1'b1, 16'h005A});
        for (int i = 0; i < 5; i++) begin
            in_valid     = i[0];
            multiplicand = 8'h11;
            multiplier   = 8'h22;
            tick();
            chk("bp_stall", {in_ready, out_valid, busy, product}, {3'b011, 16'h005A});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", {in_ready, out_valid, busy}, 3'b100);

        // Reset during the second ITER cycle aborts the op
        multiplicand = 8'd100;
        multiplier   = 8'd100;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ctrl", {in_ready, out_valid, busy}, 3'b100);
        chk("abort_product", product, 16'h0000);
        repeat (6) tick();
        chk("abort_no_result", {out_valid, busy}, 2'b00);

        // Reset wins over a simultaneous in_valid
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_vs_valid", {in_ready, busy}, 2'b10);

        do_op("t5_3xm3", 8'd3, 8'hFD, 16'hFFF7, 0);
        do_op("t_m128x127", 8'h80, 8'd127, 16'hC080, 2);
        do_op("t_m1xm1", 8'hFF, 8'hFF, 16'h0001, 1);
        do_op("t_0xm128", 8'h00, 8'h80, 16'h0000, 0);

        // Short seeded sweep with random stalls
        for (int k = 0; k < 150; k++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rexp = 16'($signed(ra) * $signed(rb));
            do_op("sweep", ra, rb, rexp, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
